keyboard_event_queue: RTL and testbench

//  Stage directly downstream of keyboard_controller. Takes its raw PS/2 byte

---
 rtl/keyboard_event_queue_if.sv | 24 ++
 rtl/keyboard_event_queue.sv | 166 ++++++++++++++++
 tb/tb_keyboard_event_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/keyboard_event_queue_if.sv
// Bus between the keyboard byte producer / CPU side and keyboard_event_queue.
// Master: drives raw bytes, pops and clears overflow. Slave: presents queued key events.
interface keyboard_event_queue_if #(
    parameter int unsigned AW = 4
);
    logic [7:0]  kb_data;
    logic        kb_valid;
    logic [9:0]  evt_data;
    logic        evt_valid;
    logic        evt_pop;
    logic [AW:0] evt_count;
    logic        overflow;
    logic        ovf_clr;

    modport master (
        output kb_data, kb_valid, evt_pop, ovf_clr,
        input  evt_data, evt_valid, evt_count, overflow
    );

    modport slave (
        input  kb_data, kb_valid, evt_pop, ovf_clr,
        output evt_data, evt_valid, evt_count, overflow
    );
endinterface

// File: rtl/keyboard_event_queue.sv
// Synchronises PS/2 set-2 bytes into sys_clk, folds E0/F0 prefixes into key events
// and queues them in a show-ahead FIFO. Optional macro: KBD_EVENT_REPEAT_FILTER_EN.
module keyboard_event_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    keyboard_event_queue_if.slave   bus
);
    localparam int unsigned EW = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_e;

    // kb_valid is asynchronous: three-flop chain, rising-edge detect on the last pair
    logic s1_q, s2_q, s3_q;
    logic strobe_c;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.kb_valid;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign strobe_c = s2_q & ~s3_q;

    state_e      state_q, state_d;
    logic        emit_c;
    logic        emit_ext_c;
    logic        emit_rel_c;
    logic [7:0]  byte_c;
    logic        is_status_c;

    assign byte_c      = bus.kb_data;
    assign is_status_c = (byte_c == 8'hAA) || (byte_c == 8'hFA) || (byte_c == 8'hEE)
                      || (byte_c == 8'hFC) || (byte_c == 8'hFE);

    always_comb begin
        state_d    = state_q;
        emit_c     = 1'b0;
        emit_ext_c = 1'b0;
        emit_rel_c = 1'b0;
        if (strobe_c) begin
            case (state_q)
                IDLE: begin
                    if (byte_c == 8'hE0)      state_d = EXT;
                    else if (byte_c == 8'hF0) state_d = BRK;
                    else if (!is_status_c)    emit_c  = 1'b1;
                end
                EXT: begin
                    if (byte_c == 8'hF0)      state_d = EXT_BRK;
                    else if (byte_c != 8'hE0) begin
                        emit_c     = 1'b1;
                        emit_ext_c = 1'b1;
                        state_d    = IDLE;
                    end
                end
                BRK: begin
                    if (byte_c == 8'hE0)      state_d = EXT_BRK;
                    else if (byte_c != 8'hF0) begin
                        emit_c     = 1'b1;
                        emit_rel_c = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    if ((byte_c != 8'hE0) && (byte_c != 8'hF0)) begin
                        emit_c     = 1'b1;
                        emit_ext_c = 1'b1;
                        emit_rel_c = 1'b1;
                        state_d    = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    logic [EW-1:0] event_c;
    logic          filt_c;
    logic          push_c;

    assign event_c = {emit_ext_c, emit_rel_c, byte_c};

`ifdef KBD_EVENT_REPEAT_FILTER_EN
    // Most recent make; a repeat of it is typematic and is suppressed
    logic       lm_valid_q;
    logic [8:0] lm_key_q;
    logic       lm_hit_c;

    assign lm_hit_c = lm_valid_q && (lm_key_q == {emit_ext_c, byte_c});
    assign filt_c   = emit_c && !emit_rel_c && lm_hit_c;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            lm_valid_q <= 1'b0;
            lm_key_q   <= 9'd0;
        end else if (emit_c) begin
            if (emit_rel_c) begin
                if (lm_hit_c) lm_valid_q <= 1'b0;
            end else if (!lm_hit_c) begin
                lm_valid_q <= 1'b1;
                lm_key_q   <= {emit_ext_c, byte_c};
            end
        end
    end
`else
    assign filt_c = 1'b0;
`endif

    assign push_c = emit_c & ~filt_c;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          empty_c, full_c, pop_c, wr_en_c;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW])
                  && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c   = bus.evt_pop & ~empty_c;
    // A full FIFO still takes a push when the head leaves on the same edge
    assign wr_en_c = push_c & (~full_c | pop_c);

    always_ff @(posedge sys_clk) begin
        if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= event_c;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_c)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (wr_en_c && !pop_c)      count_q <= count_q + (AW+1)'(1);
            else if (!wr_en_c && pop_c) count_q <= count_q - (AW+1)'(1);
            if (push_c && !wr_en_c) ovf_q <= 1'b1;
            else if (bus.ovf_clr)   ovf_q <= 1'b0;
        end
    end

    assign bus.evt_data  = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.evt_valid = ~empty_c;
    assign bus.evt_count = count_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_keyboard_event_queue.sv
// Scoreboard bench for keyboard_event_queue: stimulus queues expected events,
// a monitor compares the FIFO head each time it is popped.
`timescale 1ns/1ps
module tb_keyboard_event_queue;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    keyboard_event_queue_if #(.AW(AW)) bus ();

    keyboard_event_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    logic [7:0] kb_data  = 8'h00;
    logic       kb_valid = 1'b0;
    logic       ovf_clr  = 1'b0;
    logic       stim_pop = 1'b0;
    logic       mon_pop  = 1'b0;
    logic       mon_en   = 1'b0;

    assign bus.kb_data  = kb_data;
    assign bus.kb_valid = kb_valid;
    assign bus.ovf_clr  = ovf_clr;
    assign bus.evt_pop  = mon_pop | stim_pop;

    logic [9:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Monitor: any pop that will occur on the next edge is checked against the scoreboard
    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(negedge sys_clk);
            if (bus.evt_valid && (mon_en || stim_pop)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL evt_unexpected: got 0x%03h, none expected", bus.evt_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.evt_data !== e) begin
                        n_err++;
                        $display("FAIL evt_data: got 0x%03h expected 0x%03h", bus.evt_data, e);
                    end
                end
            end
            mon_pop = mon_en && bus.evt_valid;
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        kb_data  = b;
        kb_valid = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1 kb_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        @(posedge sys_clk); #1 mon_en = 1'b1;
        while ((exp_q.size() != 0 || bus.evt_valid) && budget < 300) begin
            @(posedge sys_clk); #1;
            budget++;
        end
        mon_en = 1'b0;
        @(posedge sys_clk); #1;
        check("drain_timeout", 16'(budget < 300), 16'd1);
        check("drain_count", 16'(bus.evt_count), 16'd0);
    endtask

    task automatic pulse_reset();
        @(posedge sys_clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    initial begin : stimulus
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_evt_valid", 16'(bus.evt_valid), 16'd0);
        check("rst_evt_count", 16'(bus.evt_count), 16'd0);
        check("rst_evt_data",  16'(bus.evt_data),  16'd0);
        check("rst_overflow",  16'(bus.overflow),  16'd0);
        rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Plain make then break
        send_byte(8'h1C); exp_q.push_back(10'h01C);
        send_byte(8'hF0); send_byte(8'h1C); exp_q.push_back(10'h11C);
        check("mk_brk_count", 16'(bus.evt_count), 16'd2);
        check("mk_brk_ovf",   16'(bus.overflow),  16'd0);
        drain();

        // Extended make/break, status byte in IDLE
        send_byte(8'hE0); send_byte(8'h75); exp_q.push_back(10'h275);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); exp_q.push_back(10'h375);
        send_byte(8'hAA);
        check("ext_count", 16'(bus.evt_count), 16'd2);
        drain();

        // Latency: valid appears after the 3rd edge following kb_valid rise
        @(posedge sys_clk); #1;
        kb_data = 8'h16; kb_valid = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk); #1;
        check("lat_edge2_valid", 16'(bus.evt_valid), 16'd0);
        @(posedge sys_clk); #1;
        check("lat_edge3_valid", 16'(bus.evt_valid), 16'd1);
        exp_q.push_back(10'h016);
        repeat (2) @(posedge sys_clk);
        #1 kb_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        drain();

        // Overflow: DEPTH+2 makes with no pops
        for (int i = 0; i < DEPTH + 2; i++) begin
            send_byte(8'(8'h10 + i));
            if (i < DEPTH) exp_q.push_back(10'(8'h10 + i));
        end
        check("ovf_count", 16'(bus.evt_count), 16'(DEPTH));
        check("ovf_flag",  16'(bus.overflow),  16'd1);
        check("ovf_head",  16'(bus.evt_data),  16'h010);
        @(posedge sys_clk); #1 ovf_clr = 1'b1;
        @(posedge sys_clk); #1 ovf_clr = 1'b0;
        check("ovf_clr", 16'(bus.overflow), 16'd0);

        // Full FIFO: pop lands on the same edge as the new push
        @(posedge sys_clk); #1;
        kb_data = 8'h30; kb_valid = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk); #1 stim_pop = 1'b1;
        @(posedge sys_clk); #1 stim_pop = 1'b0;
        exp_q.push_back(10'h030);
        check("fullpop_count", 16'(bus.evt_count), 16'(DEPTH));
        check("fullpop_ovf",   16'(bus.overflow),  16'd0);
        check("fullpop_head",  16'(bus.evt_data),  16'h011);
        repeat (2) @(posedge sys_clk);
        #1 kb_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        drain();

        // Reset after a lone E0 discards the prefix
        send_byte(8'hE0);
        pulse_reset();
        send_byte(8'h1C); exp_q.push_back(10'h01C);
        drain();

        // Typematic repeats
        pulse_reset();
        send_byte(8'h1C); exp_q.push_back(10'h01C);
        send_byte(8'h1C);
`ifndef KBD_EVENT_REPEAT_FILTER_EN
        exp_q.push_back(10'h01C);
`endif
        send_byte(8'h1C);
`ifndef KBD_EVENT_REPEAT_FILTER_EN
        exp_q.push_back(10'h01C);
`endif
        send_byte(8'hF0); send_byte(8'h1C); exp_q.push_back(10'h11C);
        send_byte(8'h1C); exp_q.push_back(10'h01C);
`ifdef KBD_EVENT_REPEAT_FILTER_EN
        check("rep_count", 16'(bus.evt_count), 16'd3);
`else
        check("rep_count", 16'(bus.evt_count), 16'd5);
`endif
        check("rep_ovf", 16'(bus.overflow), 16'd0);
        drain();

        check("scoreboard_left", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
